psrn_feeder: RTL

- Clocked controller that sits directly in front of the psrn pseudo-random generator.
- Drives psrn's level/edge-sensitive `start` and `init` inputs from a synchronous FSM.
- Samples psrn's 16-bit `rn` result after a programmable settle time and buffers results in a small first-word-fall-through FIFO.
- Presents the FIFO through a valid/ready stream, so clocked consumers never touch psrn's unclocked sequencing (the init-before-start dependency is owned here).

---
 rtl/psrn_pkg.sv | 15 +
 rtl/psrn_fifo.sv | 61 ++++++
 rtl/psrn_feeder.sv | 107 ++++++++++
 3 files changed

// File: rtl/psrn_pkg.sv
// Shared definitions for the psrn generator and its clocked feeder.
package psrn_pkg;

    localparam int RN_WIDTH = 16;

    // Seed loaded into psrn whenever psrn_init qualifies a start transition.
    localparam logic [RN_WIDTH-1:0] DEFAULT_SEED = 16'h00a3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/psrn_fifo.sv
// First-word-fall-through synchronous FIFO buffering captured psrn words.
module psrn_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign valid  = (count_q != '0);
    assign do_pop = pop && valid;
    assign count  = count_q;
    // Head word is forced to zero while empty so reset and flush present a clean bus.
    assign rdata  = valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/psrn_feeder.sv
// Clocked sequencer for psrn: orders init before start, samples rn after a
// settle delay and streams the captured words out through a FWFT FIFO.
module psrn_feeder
    import psrn_pkg::*;
#(
    parameter int WIDTH  = RN_WIDTH,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             reseed,
    output logic             psrn_start,
    output logic             psrn_init,
    input  logic [WIDTH-1:0] psrn_rn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    fill_level,
    output logic             busy
);

    state_e           state_q;
    logic             start_q;
    logic             init_q;
    logic             pend_q;
    logic [CNT_W-1:0] cnt_q;

    logic fifo_flush;
    logic fifo_push;
    logic issue;

    assign fifo_flush = (state_q == IDLE) && pend_q;
    // A capture that overlaps a pending reseed belongs to the old seed and is dropped.
    assign fifo_push  = (state_q == WAIT) && (cnt_q == '0) && !pend_q;
    assign issue      = (state_q == IDLE) && !pend_q && enable
                        && (fill_level < CW'(DEPTH));

    assign psrn_start = start_q;
    assign psrn_init  = init_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            init_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (reseed) begin
                pend_q <= 1'b1;
            end else if (fifo_flush) begin
                pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        init_q  <= 1'b1;
                        state_q <= SEED;
                    end else if (issue) begin
                        start_q <= ~start_q;
                        cnt_q   <= CNT_W'(SETTLE - 1);
                        state_q <= WAIT;
                    end
                end
                // init has been stable for a full cycle before this start edge.
                SEED: begin
                    start_q <= ~start_q;
                    cnt_q   <= CNT_W'(SETTLE - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        init_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    psrn_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(fifo_flush),
        .push (fifo_push),
        .pop  (out_ready),
        .wdata(psrn_rn),
        .rdata(out_data),
        .valid(out_valid),
        .count(fill_level)
    );

endmodule
